sd_dma: RTL
===========

# sd_dma

Sector-read DMA controller between the SPI `sd` byte engine and the 256 KB main `memory`. It reads one 512-byte SD block: CMD17, R1 poll, data-token poll, then 512 data bytes and 2 CRC bytes. Data bytes are written into main memory at a programmed base address. `core88` has no wait states, so the block takes the memory write port only in cycles where the CPU is not accessing memory. `portctl` programs it and sees completion.

## Interface
- `ADDR_W`, 18: memory address width.
- `R1_POLLS`, 8: maximum 0xFF-padded bytes while waiting for R1.
- `TOKEN_POLLS`, 4096: maximum bytes while waiting for the 0xFE token.

- `clock` in 1: CPU clock; the only clock.
- `resetn` in 1: reset; asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `lba` in 32: block address; captured at start.
- `dst` in ADDR_W: memory base; captured at start.
- `busy` out 1: high from the cycle after accepted start until DONE exits.
- `done` out 1: one-cycle pulse at end of transfer, success or error.
- `error` out 1: sticky; cleared by the next accepted start.
- `sd_signal` out 1: exchange request to `sd`.
- `sd_cmd` out 2: 0 = exchange byte, 1 = CS assert, 2 = CS deassert.
- `sd_out` out 8: byte to send.
- `sd_din` in 8: received byte.
- `sd_busy` in 1: `sd` engine busy.
- `sd_timeout` in 1: `sd` engine timeout.
- `cpu_mreq` in 1: CPU is accessing memory this cycle.
- `mem_sel` out 1: DMA owns the memory write port this cycle.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_data` out 8: write data.

## Operation
- **States:** IDLE → DESEL → SEL → CMD → R1 → TOKEN → DATA → CRC → DESEL_END → DONE → IDLE.
- **DESEL:** issue cmd 2, then one exchange of 0xFF.
- **SEL:** issue cmd 1.
- **CMD:** send 0x51, then lba[31:24], [23:16], [15:8], [7:0], then 0xFF as CRC. Six exchanges.
- **R1:** send 0xFF until `sd_din` ≠ 0xFF.
  - More than R1_POLLS polls → error.
  - R1 ≠ 0x00 → error.
- **TOKEN:** send 0xFF until `sd_din` = 0xFE.
  - Any other non-0xFF byte → error.
  - More than TOKEN_POLLS polls → error.
- **DATA:** 512 exchanges of 0xFF. Each received byte i is latched into a pending register and written to `dst`+i modulo 2^ADDR_W.
- **CRC:** two 0xFF exchanges; received bytes are discarded.
- **Error path:** set `error`, go to DESEL_END. An exchange completing with `sd_timeout`=1 is also an error.
- **Exchange handshake:**
  - Drive `sd_cmd`/`sd_out` and raise `sd_signal`.
  - Hold until `sd_busy`=1 is seen, then drop `sd_signal`.
  - Wait for `sd_busy`=0. `sd_din` is valid in that cycle.
  - Never raise `sd_signal` while `sd_busy`=1.
- **Memory write:**
  - The pending byte is written in the first cycle with `cpu_mreq`=0. `mem_sel` and `mem_we` are high for exactly that cycle.
  - The next DATA exchange is not issued until the pending byte is written.
  - The CPU always wins a simultaneous memory cycle.
- **Counters:** 10-bit byte counter, 13-bit poll counter, ADDR_W-bit address counter (wraps silently).

## Timing
- **Reset values:** IDLE; every output 0; `mem_addr` and `mem_data` 0.
- **Start:** `start` in IDLE at edge N → `busy`=1 and `sd_signal`=1 (DESEL) at N+1. `start` while busy is ignored.
- **Write latency:** `mem_we` no earlier than one cycle after the completing `sd_busy`=0 cycle. Unbounded while `cpu_mreq`=1.
- **Done:** `done` is high in the DONE cycle. `busy` falls the cycle after. `error` is valid when `done` is high.
- **Reset mid-operation:** immediate return to IDLE with all outputs 0. No memory write is completed. The CS state in `sd` is left as is; every transfer begins with DESEL.
- **Simultaneous events:** `sd_timeout` together with a matching byte counts as error.

## Structure
- Package `sd_dma_pkg` holds:
  - the state enum;
  - the `SD_CMD_XCHG`/`SEL`/`DESEL` codes;
  - constants `CMD17`=0x51, `DATA_TOKEN`=0xFE, `BLOCK_BYTES`=512.
- Sub-module `sd_xchg`: a one-exchange handshake FSM with `go`/`ack`/`rx` toward `sd_dma`.

## Test plan
- **Good read:** lba=0x00001234, dst=0x10000; model replies R1=0x00, 3×0xFF, 0xFE, then data bytes i&0xFF. Expect:
  - sent bytes 51 00 00 12 34 FF;
  - memory 0x10000..0x101FF = 00..FF twice;
  - `done`, `error`=0;
  - CS deasserted at the end.
- **Bad R1:** R1=0x04 → `error`=1, `done` pulse, no `mem_we`, CS deasserted.
- **Token timeout:** model sends 0xFF forever → error after exactly 4096 token polls.
- **CPU contention:** `cpu_mreq`=1 for 50 cycles in mid-DATA → `mem_we` never coincides with `cpu_mreq`; all 512 bytes correct.
- **Address wrap:** dst=0x3FF00 → bytes 256..511 land at 0x00000..0x000FF.
- **Reset and ignored start:** `resetn` low during DATA byte 100 → outputs 0 at once; a new start completes cleanly. `start` while busy has no effect.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// sd_dma_pkg: shared states, sd command codes and protocol constants for the sector-read DMA.
package sd_dma_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_DESEL, S_SEL, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_DESEL_END, S_DONE
  } state_t;
  typedef enum logic [1:0] {X_IDLE, X_REQ, X_WAIT} xstate_t;
  localparam logic [1:0] SD_CMD_XCHG  = 2'd0;
  localparam logic [1:0] SD_CMD_SEL   = 2'd1;
  localparam logic [1:0] SD_CMD_DESEL = 2'd2;
  localparam logic [7:0] CMD17        = 8'h51;
  localparam logic [7:0] DATA_TOKEN   = 8'hFE;
  localparam logic [7:0] PAD          = 8'hFF;
  localparam int         BLOCK_BYTES  = 512;
endpackage

// File: rtl/sd_xchg.sv
// sd_xchg: one request/busy/idle handshake with the sd byte engine.
module sd_xchg
  import sd_dma_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       go,
  input  logic       sd_busy,
  input  logic       sd_timeout,
  input  logic [7:0] sd_din,
  output logic       sd_signal,
  output logic       ack,
  output logic       tmo,
  output logic [7:0] rx
);
  xstate_t state, nxt;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= X_IDLE;
    else state <= nxt;

  always_comb
    nxt = (state == X_IDLE) ? ((go && !sd_busy) ? X_REQ : X_IDLE) :
          (state == X_REQ)  ? (sd_busy ? X_WAIT : X_REQ) :
                              (sd_busy ? X_WAIT : X_IDLE);

  // the request is raised combinationally so an exchange starts in the cycle it is wanted
  always_comb begin
    sd_signal = (state == X_REQ) || (state == X_IDLE && go && !sd_busy);
    ack       = (state == X_WAIT) && !sd_busy;
    tmo       = sd_timeout;
    rx        = sd_din;
  end
endmodule

// File: rtl/sd_dma.sv
// sd_dma: reads one 512-byte SD block via CMD17 and writes it to main memory
// in cycles the CPU leaves the memory port free.
module sd_dma
  import sd_dma_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int R1_POLLS    = 8,
  parameter int TOKEN_POLLS = 4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [31:0]       lba,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              sd_signal,
  output logic [1:0]        sd_cmd,
  output logic [7:0]        sd_out,
  input  logic [7:0]        sd_din,
  input  logic              sd_busy,
  input  logic              sd_timeout,
  input  logic              cpu_mreq,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data
);
  localparam logic [9:0]  LAST_BYTE = 10'(BLOCK_BYTES - 1);
  localparam logic [12:0] R1_LAST   = 13'(R1_POLLS - 1);
  localparam logic [12:0] TOK_LAST  = 13'(TOKEN_POLLS - 1);

  state_t      state, nxt;
  logic [31:0] lba_q;
  logic [9:0]  cnt;
  logic [12:0] poll;
  logic        pending, go, ack, tmo, fail;
  logic [7:0]  rx;

  sd_xchg u_xchg (
    .clock     (clock),
    .resetn    (resetn),
    .go        (go),
    .sd_busy   (sd_busy),
    .sd_timeout(sd_timeout),
    .sd_din    (sd_din),
    .sd_signal (sd_signal),
    .ack       (ack),
    .tmo       (tmo),
    .rx        (rx)
  );

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else state <= nxt;

  always_comb begin
    fail = ack && state != S_DESEL_END && (tmo ||
           (state == S_R1    && (rx == PAD ? poll == R1_LAST  : rx != 8'h00)) ||
           (state == S_TOKEN && (rx == PAD ? poll == TOK_LAST : rx != DATA_TOKEN)));
    nxt = state;
    case (state)
      S_IDLE:      if (start) nxt = S_DESEL;
      S_DESEL:     if (ack && cnt == 10'd1) nxt = S_SEL;
      S_SEL:       if (ack) nxt = S_CMD;
      S_CMD:       if (ack && cnt == 10'd5) nxt = S_R1;
      S_R1:        if (ack && rx != PAD) nxt = S_TOKEN;
      S_TOKEN:     if (ack && rx == DATA_TOKEN) nxt = S_DATA;
      S_DATA:      if (ack && cnt == LAST_BYTE) nxt = S_CRC;
      S_CRC:       if (ack && cnt == 10'd1) nxt = S_DESEL_END;
      S_DESEL_END: if (ack) nxt = S_DONE;
      default:     nxt = S_IDLE;
    endcase
    if (fail) nxt = S_DESEL_END;
  end

  // an exchange waits for the previous data byte to reach memory
  always_comb begin
    busy    = state != S_IDLE;
    done    = state == S_DONE;
    go      = !(state inside {S_IDLE, S_DONE}) && !pending;
    sd_cmd  = (state == S_SEL) ? SD_CMD_SEL :
              (state == S_DESEL_END || (state == S_DESEL && cnt == 10'd0)) ? SD_CMD_DESEL : SD_CMD_XCHG;
    sd_out  = (state == S_IDLE) ? 8'h00 :
              (state != S_CMD)  ? PAD :
              (cnt == 10'd0) ? CMD17 :
              (cnt == 10'd1) ? lba_q[31:24] :
              (cnt == 10'd2) ? lba_q[23:16] :
              (cnt == 10'd3) ? lba_q[15:8] :
              (cnt == 10'd4) ? lba_q[7:0] : PAD;
    mem_we  = pending && !cpu_mreq;
    mem_sel = mem_we;
  end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      lba_q    <= '0;
      cnt      <= '0;
      poll     <= '0;
      error    <= 1'b0;
      pending  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      cnt  <= (nxt != state) ? '0 : cnt + 10'(ack);
      poll <= (nxt != state) ? '0 : poll + 13'(ack);
      if (state == S_IDLE && start) begin
        lba_q    <= lba;
        mem_addr <= dst;
        error    <= 1'b0;
      end
      if (fail) error <= 1'b1;
      if (state == S_DATA && ack && !tmo) begin
        pending  <= 1'b1;
        mem_data <= rx;
      end else if (mem_we) begin
        pending  <= 1'b0;
        mem_addr <= mem_addr + 1'b1;
      end
    end
endmodule
